// File: rtl/output_shifter_register_if.sv
// output_shifter_register_if
//   Bus between an array column's result stream and its output shifter.
//   master: column/drain controller side (drives in_valid, in, out_en).
//   slave : output_shifter_register side (drives out, out_valid, full,
//           busy, skew_cnt and, with OUTPUT_SHIFTER_OVF_EN, ovf).
//   skew_cnt is a debug observation of the shifter's skew countdown.
// Global macros: DATASIZE, ARRAYWIDTH, DSP_DELAY (defaults below).
// Optional feature macro: OUTPUT_SHIFTER_OVF_EN (adds ovf).

`ifndef DATASIZE
`define DATASIZE 16
`endif
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DSP_DELAY
`define DSP_DELAY 3
`endif

interface output_shifter_register_if;
    logic                 in_valid;
    logic [`DATASIZE-1:0] in;
    logic                 out_en;
    logic [`DATASIZE-1:0] out;
    logic                 out_valid;
    logic                 full;
    logic                 busy;
    logic [7:0]           skew_cnt;
`ifdef OUTPUT_SHIFTER_OVF_EN
    logic                 ovf;
`endif

    modport master (
        output in_valid,
        output in,
        output out_en,
`ifdef OUTPUT_SHIFTER_OVF_EN
        input  ovf,
`endif
        input  out,
        input  out_valid,
        input  full,
        input  busy,
        input  skew_cnt
    );

    modport slave (
        input  in_valid,
        input  in,
        input  out_en,
`ifdef OUTPUT_SHIFTER_OVF_EN
        output ovf,
`endif
        output out,
        output out_valid,
        output full,
        output busy,
        output skew_cnt
    );
endinterface

// File: rtl/output_shifter_register.sv
// output_shifter_register
//   Per-column result collector at the bottom of the systolic array.
//   Captures ARRAYWIDTH serial results in arrival order, holds them, then
//   drains them on a broadcast out_en so all columns emit the same row on
//   the same cycle, removing the input-side skew.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - output_shifter_register_if.slave
//          in_valid/in : column result stream
//          out_en      : drain request (common to all columns)
//          out/out_valid : registered drained word (out=0 when not valid)
//          full        : whole tile captured, not yet draining
//          busy        : not idle
//          skew_cnt    : debug skew countdown, no behavioural effect
//          ovf         : sticky dropped-write flag (OUTPUT_SHIFTER_OVF_EN)
// Parameter: DELAY_NUM - column index, only sets skew_cnt reset value.
// Optional feature macro: OUTPUT_SHIFTER_OVF_EN.

`ifndef DATASIZE
`define DATASIZE 16
`endif
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DSP_DELAY
`define DSP_DELAY 3
`endif

module output_shifter_register #(
    parameter int DELAY_NUM = 0
) (
    input logic                       clk,
    input logic                       rst,
    output_shifter_register_if.slave  bus
);
    localparam int AW        = `ARRAYWIDTH;
    localparam int DW        = `DATASIZE;
    localparam int IDXW      = (AW > 1) ? $clog2(AW) : 1;
    localparam int SKEW_PROD = (`DSP_DELAY - 1) * DELAY_NUM;
    localparam logic [7:0] SKEW_INIT = (SKEW_PROD > 0) ? 8'(SKEW_PROD) : 8'd0;
    localparam logic [7:0] LAST_IDX  = 8'(AW - 1);
    localparam logic [7:0] AW_CNT    = 8'(AW);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HOLD,
        DRAIN
    } state_t;

    state_t          state_q;
    logic [7:0]      wcnt_q;
    logic [7:0]      rcnt_q;
    logic [7:0]      skew_cnt_q;
    logic [DW-1:0]   out_q;
    logic            out_valid_q;

    logic [DW-1:0]   mem [AW];

    logic            wr_en;
    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] rd_idx;

    always_comb begin
        wr_en  = bus.in_valid && ((state_q == IDLE) || (state_q == CAPTURE));
        wr_idx = (state_q == IDLE) ? '0 : wcnt_q[IDXW-1:0];
        rd_idx = (state_q == HOLD) ? '0 : rcnt_q[IDXW-1:0];
    end

    // Storage is deliberately not reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            skew_cnt_q  <= SKEW_INIT;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // in_valid takes priority; out_en is meaningless here.
                    if (bus.in_valid) begin
                        wcnt_q  <= 8'd1;
                        state_q <= (AW == 1) ? HOLD : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (skew_cnt_q != '0) begin
                        skew_cnt_q <= skew_cnt_q - 8'd1;
                    end
                    if (bus.in_valid) begin
                        wcnt_q <= wcnt_q + 8'd1;
                        if (wcnt_q == LAST_IDX) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Word 0 is issued on the HOLD->DRAIN edge, so the read
                    // pointer restarts at 0 and is already advanced past it.
                    if (bus.out_en) begin
                        out_q       <= mem[rd_idx];
                        out_valid_q <= 1'b1;
                        rcnt_q      <= 8'd1;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave one cycle after the last word so busy drops
                    // the cycle after the final valid output.
                    if (rcnt_q == AW_CNT) begin
                        state_q <= IDLE;
                        wcnt_q  <= '0;
                    end else if (bus.out_en) begin
                        out_q       <= mem[rd_idx];
                        out_valid_q <= 1'b1;
                        rcnt_q      <= rcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.full      = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.skew_cnt  = skew_cnt_q;

`ifdef OUTPUT_SHIFTER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid && ((state_q == HOLD) || (state_q == DRAIN))) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    // Writes arriving in HOLD or DRAIN are dropped without any indication.
`endif

endmodule

// File: tb/tb_output_shifter_register.sv
// tb_output_shifter_register
//   Directed bench for output_shifter_register (ARRAYWIDTH=4, DSP_DELAY=3).
//   Two instances: u0 (DELAY_NUM=0) and u1 (DELAY_NUM=3). Expected words
//   are queued when written and popped when out_valid is observed.

`ifndef DATASIZE
`define DATASIZE 16
`endif
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DSP_DELAY
`define DSP_DELAY 3
`endif

module tb_output_shifter_register;
    logic clk;
    logic rst;

    output_shifter_register_if a0 ();
    output_shifter_register_if a1 ();

    output_shifter_register #(.DELAY_NUM(0)) u0 (.clk(clk), .rst(rst), .bus(a0));
    output_shifter_register #(.DELAY_NUM(3)) u1 (.clk(clk), .rst(rst), .bus(a1));

    logic [`DATASIZE-1:0] q0[$];
    logic [`DATASIZE-1:0] q1[$];
    int checks;
    int errors;
    bit align;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        logic avail;
        if (a0.out_valid === 1'b1) begin
            avail = (q0.size() != 0);
            chk("u0_sb_nonempty", 32'(avail), 32'd1);
            if (avail) chk("u0_word", 32'(a0.out), 32'(q0.pop_front()));
        end else begin
            chk("u0_idle_zero", 32'(a0.out), 32'd0);
        end
        if (a1.out_valid === 1'b1) begin
            avail = (q1.size() != 0);
            chk("u1_sb_nonempty", 32'(avail), 32'd1);
            if (avail) chk("u1_word", 32'(a1.out), 32'(q1.pop_front()));
        end else begin
            chk("u1_idle_zero", 32'(a1.out), 32'd0);
        end
        if (align) begin
            chk("align_valid", 32'(a1.out_valid), 32'(a0.out_valid));
            chk("align_word", 32'(a1.out), 32'(a0.out));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic wr(input int v);
        a0.in_valid = 1'b1;
        a0.in = `DATASIZE'(v);
        q0.push_back(`DATASIZE'(v));
        tick();
        a0.in_valid = 1'b0;
    endtask

    task automatic drain(output int ncyc);
        ncyc = 0;
        a0.out_en = 1'b1;
        a1.out_en = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && ncyc < 20) begin
            tick();
            ncyc++;
            if (ncyc == 1) begin
                chk("full_falls", 32'(a0.full), 32'd0);
                chk("first_valid", 32'(a0.out_valid), 32'd1);
            end
        end
        a0.out_en = 1'b0;
        a1.out_en = 1'b0;
        chk("drain_done", 32'(q0.size() + q1.size()), 32'd0);
        tick();
        chk("busy_after_drain", 32'(a0.busy), 32'd0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        align = 1'b0;
        rst = 1'b0;
        a0.in_valid = 1'b0; a0.in = '0; a0.out_en = 1'b0;
        a1.in_valid = 1'b0; a1.in = '0; a1.out_en = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(a0.out), 32'd0);
        chk("rst_valid", 32'(a0.out_valid), 32'd0);
        chk("rst_full", 32'(a0.full), 32'd0);
        chk("rst_busy", 32'(a0.busy), 32'd0);
        chk("rst_skew0", 32'(a0.skew_cnt), 32'd0);
        chk("rst_skew1", 32'(a1.skew_cnt), 32'd6);
`ifdef OUTPUT_SHIFTER_OVF_EN
        chk("rst_ovf", 32'(a0.ovf), 32'd0);
`endif
        rst = 1'b1;
        tick();

        // Nominal capture and full-rate drain
        wr(1); wr(2); wr(3);
        chk("nom_full_early", 32'(a0.full), 32'd0);
        chk("nom_busy", 32'(a0.busy), 32'd1);
        wr(4);
        chk("nom_full", 32'(a0.full), 32'd1);
        drain(n);
        chk("nom_len", 32'(n), 32'd4);

        // Back-to-back: in_valid with out_en in IDLE, then gapped capture
        a0.out_en = 1'b1;
        wr(5);
        a0.out_en = 1'b0;
        chk("idle_prio_valid", 32'(a0.out_valid), 32'd0);
        chk("idle_prio_busy", 32'(a0.busy), 32'd1);
        tick();
        tick();
        chk("gap_full", 32'(a0.full), 32'd0);
        chk("gap_busy", 32'(a0.busy), 32'd1);
        wr(6); wr(7);
        chk("gap_full7", 32'(a0.full), 32'd0);
        wr(8);
        chk("gap_full8", 32'(a0.full), 32'd1);
        drain(n);
        chk("gap_len", 32'(n), 32'd4);

        // Paused drain: out_en 1,0,1,1,1
        wr(1); wr(2); wr(3); wr(4);
        a0.out_en = 1'b1; tick();
        a0.out_en = 1'b0; tick();
        chk("pause_valid", 32'(a0.out_valid), 32'd0);
        a0.out_en = 1'b1; tick(); tick(); tick();
        a0.out_en = 1'b0;
        chk("pause_sb", 32'(q0.size()), 32'd0);
        tick();
        chk("pause_busy", 32'(a0.busy), 32'd0);

        // Dropped write while full
        wr(1); wr(2); wr(3); wr(4);
        a0.in_valid = 1'b1; a0.in = `DATASIZE'(9);
        tick();
        a0.in_valid = 1'b0;
        chk("drop_full", 32'(a0.full), 32'd1);
`ifdef OUTPUT_SHIFTER_OVF_EN
        chk("ovf_set", 32'(a0.ovf), 32'd1);
`endif
        drain(n);
        chk("drop_len", 32'(n), 32'd4);
`ifdef OUTPUT_SHIFTER_OVF_EN
        chk("ovf_sticky", 32'(a0.ovf), 32'd1);
`endif

        // Async reset mid-drain
        wr(1); wr(2); wr(3); wr(4);
        a0.out_en = 1'b1;
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_out", 32'(a0.out), 32'd0);
        chk("arst_valid", 32'(a0.out_valid), 32'd0);
        chk("arst_busy", 32'(a0.busy), 32'd0);
`ifdef OUTPUT_SHIFTER_OVF_EN
        chk("arst_ovf", 32'(a0.ovf), 32'd0);
`endif
        q0.delete();
        a0.out_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        wr(10); wr(11); wr(12); wr(13);
        drain(n);
        chk("arst_len", 32'(n), 32'd4);

        // Multi-column: u1 fed 6 cycles after u0, common out_en
        for (int c = 0; c < 10; c++) begin
            a0.in_valid = (c < 4);
            a0.in = `DATASIZE'(20 + c);
            if (c < 4) q0.push_back(`DATASIZE'(20 + c));
            a1.in_valid = (c >= 6);
            a1.in = `DATASIZE'(14 + c);
            if (c >= 6) q1.push_back(`DATASIZE'(14 + c));
            tick();
        end
        a0.in_valid = 1'b0;
        a1.in_valid = 1'b0;
        chk("mc_full0", 32'(a0.full), 32'd1);
        chk("mc_full1", 32'(a1.full), 32'd1);
        align = 1'b1;
        drain(n);
        align = 1'b0;
        chk("mc_len", 32'(n), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
